// File: rtl/capture_frame_ctrl.sv
// Frame-level capture sequencer: arms on host start, optionally drops frames, then gates
// ov7670_capture for exactly one frame while counting lines from a passive m_axis tap.
module capture_frame_ctrl #(
  parameter int unsigned LINES_PER_FRAME = 480,
  parameter int unsigned TIMEOUT_CYCLES  = 2000000,
  parameter int unsigned SKIP_W          = 4
) (
  input  logic              m_axis_aclk,
  input  logic              m_axis_aresetn,
  input  logic              ctrl_start,
  input  logic              ctrl_stop,
  input  logic              ctrl_continuous,
  input  logic [SKIP_W-1:0] ctrl_skip,
  input  logic              fsync,
  input  logic              mon_tvalid,
  input  logic              mon_tready,
  input  logic              mon_tlast,
  output logic              cap_enable,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [15:0]       frame_count,
  output logic [15:0]       line_count
);

  localparam int unsigned     TO_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]     LINE_LAST = 16'(LINES_PER_FRAME - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        fsync_sync_q, fsync_sync_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              stop_pending_q, stop_pending_d;
  logic              cap_enable_q, cap_enable_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [15:0]       line_count_q, line_count_d;

  logic fs_edge, beat, cap_beat, timeout;

  // fsync_sync_q[0]/[1] form the synchronizer, [2] is the edge-detect delay
  assign fs_edge  = fsync_sync_q[1] & ~fsync_sync_q[2];
  assign beat     = mon_tvalid & mon_tready & mon_tlast;
  assign cap_beat = beat && (state_q == ST_CAPTURE);
  assign timeout  = (to_cnt_q == TO_LAST);

  always_comb begin
    state_d        = state_q;
    fsync_sync_d   = {fsync_sync_q[1:0], fsync};
    skip_cnt_d     = skip_cnt_q;
    stop_pending_d = 1'b0;
    err_code_d     = err_code_q;
    frame_count_d  = frame_count_q;
    line_count_d   = line_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_start && !ctrl_stop) begin
          state_d    = ST_ARM;
          err_code_d = '0;
          skip_cnt_d = ctrl_skip;
        end
      end
      ST_ARM: begin
        if (ctrl_stop) begin
          state_d = ST_IDLE;
        end else if (fs_edge) begin
          if (skip_cnt_q != '0) begin
            skip_cnt_d = skip_cnt_q - 1'b1;
          end else begin
            state_d      = ST_CAPTURE;
            line_count_d = '0;
          end
        end else if (timeout) begin
          state_d    = ST_ERR;
          err_code_d = 2'b10;
        end
      end
      ST_CAPTURE: begin
        // A stop only takes effect after the frame finishes; the frame is never truncated.
        stop_pending_d = stop_pending_q | ctrl_stop;
        if (beat) line_count_d = line_count_q + 1'b1;
        if (beat && line_count_q == LINE_LAST) begin
          state_d       = ST_DONE;
          frame_count_d = frame_count_q + 1'b1;
        end else if (fs_edge) begin
          state_d    = ST_ERR;
          err_code_d = 2'b01;
        end else if (timeout && !beat) begin
          state_d    = ST_ERR;
          err_code_d = 2'b10;
        end
      end
      ST_DONE: begin
        if (ctrl_continuous && !stop_pending_q && !ctrl_stop) begin
          state_d    = ST_ARM;
          skip_cnt_d = ctrl_skip;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_ARM || state_q == ST_CAPTURE) && state_d == state_q && !cap_beat)
      to_cnt_d = to_cnt_q + 1'b1;
    else
      to_cnt_d = '0;

    cap_enable_d = (state_d == ST_CAPTURE);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
    frame_err_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q        <= ST_IDLE;
      fsync_sync_q   <= '0;
      skip_cnt_q     <= '0;
      to_cnt_q       <= '0;
      stop_pending_q <= 1'b0;
      cap_enable_q   <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      err_code_q     <= '0;
      frame_count_q  <= '0;
      line_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      fsync_sync_q   <= fsync_sync_d;
      skip_cnt_q     <= skip_cnt_d;
      to_cnt_q       <= to_cnt_d;
      stop_pending_q <= stop_pending_d;
      cap_enable_q   <= cap_enable_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      frame_err_q    <= frame_err_d;
      err_code_q     <= err_code_d;
      frame_count_q  <= frame_count_d;
      line_count_q   <= line_count_d;
    end
  end

  assign cap_enable  = cap_enable_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign frame_count = frame_count_q;
  assign line_count  = line_count_q;

endmodule
